gba_irq_ctrl: RTL

//  Interrupt controller; the receiving end of the IRP_* pulses raised by display timing, timers,
//  DMA, serial, keypad and gamepak. Holds IE (0x200), IF (0x202) and IME (0x208) on the gb_bus.

---
 rtl/gba_irq_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/gba_irq_ctrl.sv
// GBA interrupt controller: IE/IF/IME registers on gb_bus, edge capture of interrupt sources,
// a delayed CPU IRQ line and an IME-independent HALT wake request.
module gba_irq_ctrl #(
    parameter int IRQ_DELAY = 3,
    parameter int IRQ_BITS  = 14
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic [31:0] gb_bus_din,
    output logic [31:0] gb_bus_dout,
    input  logic [27:0] gb_bus_adr,
    input  logic        gb_bus_rnw,
    input  logic        gb_bus_ena,
    input  logic [3:0]  gb_bus_be,
    input  logic [13:0] irq_src,
    output logic        cpu_irq,
    output logic        halt_wake,
    output logic [15:0] if_debug
);
    localparam logic [27:0] ADR_IE_IF = 28'h200;
    localparam logic [27:0] ADR_IME   = 28'h208;
    localparam logic [15:0] IMPL_MASK = 16'((32'd1 << IRQ_BITS) - 32'd1);

    logic [15:0] ie_q, ie_d;
    logic [15:0] if_q, if_d;
    logic        ime_q, ime_d;
    logic [13:0] src_prev_q;
    logic        armed_q;
    logic        halt_wake_q;
    logic        dout_en_q, dout_en_d;
    logic [31:0] reg_dout_q, reg_dout_d;
    logic        irq_pipe_q [0:IRQ_DELAY];

    logic        hit_ie_if, hit_ime;
    logic [15:0] set_vec, clr_vec;
    logic        req_d;

    always_comb begin
        hit_ie_if  = gb_bus_ena && (gb_bus_adr == ADR_IE_IF);
        hit_ime    = gb_bus_ena && (gb_bus_adr == ADR_IME);
        set_vec    = '0;
        clr_vec    = '0;
        ie_d       = ie_q;
        ime_d      = ime_q;

        // armed_q is low for the first cycle after reset so a source held high
        // across reset release is treated as already seen, not as a new edge.
        if (armed_q) begin
            set_vec = {2'b00, irq_src & ~src_prev_q} & IMPL_MASK;
        end

        if (hit_ie_if && !gb_bus_rnw) begin
            if (gb_bus_be[0]) ie_d[7:0]     = gb_bus_din[7:0];
            if (gb_bus_be[1]) ie_d[15:8]    = gb_bus_din[15:8];
            if (gb_bus_be[2]) clr_vec[7:0]  = gb_bus_din[23:16];
            if (gb_bus_be[3]) clr_vec[15:8] = gb_bus_din[31:24];
        end
        ie_d = ie_d & IMPL_MASK;

        if (hit_ime && !gb_bus_rnw && gb_bus_be[0]) begin
            ime_d = gb_bus_din[0];
        end

        // Set is OR-ed in after the clear so a same-cycle edge wins.
        if_d = ((if_q & ~clr_vec) | set_vec) & IMPL_MASK;

        dout_en_d  = (hit_ie_if || hit_ime) && gb_bus_rnw;
        reg_dout_d = hit_ie_if ? {if_q, ie_q} : {31'b0, ime_q};

        req_d = ime_q && (|(ie_q & if_q));
    end

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            ie_q        <= '0;
            if_q        <= '0;
            ime_q       <= 1'b0;
            src_prev_q  <= '0;
            armed_q     <= 1'b0;
            halt_wake_q <= 1'b0;
            dout_en_q   <= 1'b0;
            reg_dout_q  <= '0;
            for (int i = 0; i <= IRQ_DELAY; i++) begin
                irq_pipe_q[i] <= 1'b0;
            end
        end else begin
            ie_q        <= ie_d;
            if_q        <= if_d;
            ime_q       <= ime_d;
            src_prev_q  <= irq_src;
            armed_q     <= 1'b1;
            halt_wake_q <= |(ie_q & if_q);
            dout_en_q   <= dout_en_d;
            reg_dout_q  <= reg_dout_d;
            irq_pipe_q[0] <= req_d;
            for (int i = 1; i <= IRQ_DELAY; i++) begin
                irq_pipe_q[i] <= irq_pipe_q[i-1];
            end
        end
    end

    assign cpu_irq     = irq_pipe_q[IRQ_DELAY];
    assign halt_wake   = halt_wake_q;
    assign if_debug    = if_q;
    assign gb_bus_dout = dout_en_q ? reg_dout_q : 'z;

endmodule
